// File: rtl/fifo_dest_router_pkg.sv
// Shared constants and helpers for the FIFO destination router.
//   WORD_SIZE  : routed word width (word passes through unmodified)
//   DEST_BITS  : width of the destination field held in the word MSBs
//   NUM_DEST   : number of destination ports (2**DEST_BITS)
//   RD_LAT     : cycles from an upstream pop edge to valid read data
//   SKID_DEPTH : skid entries needed to absorb every in-flight pop
package fifo_dest_router_pkg;

    localparam int unsigned WORD_SIZE  = 6;
    localparam int unsigned DEST_BITS  = 2;
    localparam int unsigned NUM_DEST   = 4;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned SKID_DEPTH = RD_LAT + 1;

    // Pointer and count widths for the skid (count reaches SKID_DEPTH).
    localparam int unsigned SKID_PTR_W = 2;
    localparam int unsigned SKID_CNT_W = 2;
    // Width of the in-flight pop count and of skid+in-flight occupancy sums.
    localparam int unsigned INFL_W     = 2;
    localparam int unsigned OCC_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // nothing in flight, skid empty, no push pending
        ST_RUN   = 2'd1,   // words moving through pipe/skid
        ST_BLOCK = 2'd2    // skid head held by destination backpressure
    } route_state_e;

    // Destination index carried in the word MSBs.
    function automatic logic [DEST_BITS-1:0] dest_of(input logic [WORD_SIZE-1:0] word);
        return word[WORD_SIZE-1 -: DEST_BITS];
    endfunction

endpackage

// File: rtl/fifo_dest_router_skid.sv
// Circular skid buffer that absorbs the upstream read latency.
//   clk, reset_L : clock, async active-low reset
//   wr_en/wr_data: capture one word
//   rd_en        : dequeue the head (caller guarantees head_valid_c)
//   head_c       : current head word, head_valid_c: skid not empty
//   count        : registered occupancy, 0..DEPTH
module router_skid #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned PTR_W = 2,
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] head_c,
    output logic             head_valid_c,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer and occupancy bookkeeping; write+dequeue leaves count unchanged.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Data storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign head_c       = mem[rd_ptr];
    assign head_valid_c = (count != '0);

    skid_no_overflow: assert property (@(posedge clk) disable iff (!reset_L)
        !(wr_en && (count == CNT_W'(DEPTH))))
        else $error("router_skid: write into full skid");

endmodule

// File: rtl/fifo_dest_router.sv
// Pops words from an upstream FIFO, absorbs its read latency in a skid and
// routes each word in order to the destination named by its MSBs.
//   clk, reset_L        : clock, async active-low reset
//   enable              : allow new pops; 0 drains in-flight words
//   fifo_empty/_almost_empty/_data_out : upstream FIFO status and data
//   fifo_rd             : pop request (combinational from registered state)
//   dest_almost_full    : per-destination backpressure
//   dest_data_out       : routed word, shared by all destinations
//   dest_push           : one-hot push strobe, one cycle per word
//   idle                : nothing in flight, skid empty, no push this cycle
//   skid_count          : skid occupancy
module fifo_dest_router
    import fifo_dest_router_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_almost_empty,
    input  logic [WORD_SIZE-1:0]  fifo_data_out,
    output logic                  fifo_rd,
    input  logic [NUM_DEST-1:0]   dest_almost_full,
    output logic [WORD_SIZE-1:0]  dest_data_out,
    output logic [NUM_DEST-1:0]   dest_push,
    output logic                  idle,
    output logic [SKID_CNT_W-1:0] skid_count
);

    route_state_e         state_q;
    route_state_e         state_d;
    logic [RD_LAT-1:0]    vld_q;        // bit 0 = newest pop
    logic [RD_LAT-1:0]    vld_d;
    logic                 rd_prev_q;
    logic                 run_q;        // holds pops off until after reset release
    logic [WORD_SIZE-1:0] head_c;
    logic                 head_valid_c;
    logic [DEST_BITS-1:0] head_dest_c;
    logic                 blocked_c;
    logic                 deq_c;
    logic                 pop_c;
    logic [INFL_W-1:0]    inflight_c;
    logic [OCC_W-1:0]     occ_c;
    logic [OCC_W-1:0]     cnt_next_c;
    logic                 busy_next_c;
    logic [NUM_DEST-1:0]  push_d;

    router_skid #(
        .WIDTH (WORD_SIZE),
        .DEPTH (SKID_DEPTH),
        .PTR_W (SKID_PTR_W),
        .CNT_W (SKID_CNT_W)
    ) u_skid (
        .clk          (clk),
        .reset_L      (reset_L),
        .wr_en        (vld_q[RD_LAT-1]),
        .wr_data      (fifo_data_out),
        .rd_en        (deq_c),
        .head_c       (head_c),
        .head_valid_c (head_valid_c),
        .count        (skid_count)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state: idle only when the coming cycle has nothing in flight,
    // an empty skid and no push strobe.
    always_comb begin
        state_d     = state_q;
        vld_d       = {vld_q[RD_LAT-2:0], pop_c};
        cnt_next_c  = OCC_W'(skid_count) + OCC_W'(vld_q[RD_LAT-1]) - OCC_W'(deq_c);
        busy_next_c = (|vld_d) || (cnt_next_c != '0) || deq_c;
        if (!busy_next_c)                  state_d = ST_IDLE;
        else if (head_valid_c && blocked_c) state_d = ST_BLOCK;
        else                               state_d = ST_RUN;
    end

    // Outputs: route decision for the skid head and pop gating.
    always_comb begin
        head_dest_c = dest_of(head_c);
        blocked_c   = dest_almost_full[head_dest_c];
        deq_c       = head_valid_c && !blocked_c;
        push_d      = deq_c ? (NUM_DEST'(1) << head_dest_c) : '0;
        inflight_c  = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight_c = inflight_c + INFL_W'(vld_q[i]);
        end
        // Reserve a skid slot for every word already popped, net of this
        // cycle's dequeue. Flags lag a pop by one cycle, so with one word
        // left never pop back-to-back.
        occ_c = OCC_W'(skid_count) + OCC_W'(inflight_c) - OCC_W'(deq_c);
        pop_c = run_q && enable && !fifo_empty
             && (occ_c < OCC_W'(SKID_DEPTH))
             && (!fifo_almost_empty || !rd_prev_q);
    end

    // Pop tracking pipe and registered destination outputs.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            vld_q         <= '0;
            rd_prev_q     <= 1'b0;
            run_q         <= 1'b0;
            dest_push     <= '0;
            dest_data_out <= '0;
        end else begin
            vld_q     <= vld_d;
            rd_prev_q <= pop_c;
            run_q     <= 1'b1;
            dest_push <= push_d;
            if (deq_c) dest_data_out <= head_c;
        end
    end

    assign fifo_rd = pop_c;
    assign idle    = (state_q == ST_IDLE);

endmodule

// File: tb/tb_fifo_dest_router.sv
module tb_fifo_dest_router;
    import fifo_dest_router_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset_L = 1'b0;
    logic                  enable = 1'b0;
    logic                  fifo_empty = 1'b1;
    logic                  fifo_almost_empty = 1'b1;
    logic [WORD_SIZE-1:0]  fifo_data_out = '0;
    logic                  fifo_rd;
    logic [NUM_DEST-1:0]   dest_almost_full = '0;
    logic [WORD_SIZE-1:0]  dest_data_out;
    logic [NUM_DEST-1:0]   dest_push;
    logic                  idle;
    logic [SKID_CNT_W-1:0] skid_count;

    always #5 clk = ~clk;

    fifo_dest_router dut (
        .clk               (clk),
        .reset_L           (reset_L),
        .enable            (enable),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_data_out     (fifo_data_out),
        .fifo_rd           (fifo_rd),
        .dest_almost_full  (dest_almost_full),
        .dest_data_out     (dest_data_out),
        .dest_push         (dest_push),
        .idle              (idle),
        .skid_count        (skid_count)
    );

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [5:0] fq[$];      // upstream FIFO contents
    logic [5:0] src_q[$];   // words waiting to be written into the FIFO
    logic [5:0] exp_q[$];   // scoreboard, in FIFO order
    int         rd_log[$];
    int         push_log[$];
    logic [5:0] rd_d1 = '0;
    logic       rd_seen = 1'b0;
    logic [3:0] af_last = '0;
    int         cnt_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] onehot_of(input logic [5:0] w);
        logic [1:0] d;
        d = w[5:4];
        return 4'b0001 << d;
    endfunction

    always @(posedge clk) cyc++;

    // 4-entry FIFO model: two-stage read data, flags lagging one cycle.
    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            fq.delete();
            src_q.delete();
            exp_q.delete();
            rd_d1             <= '0;
            fifo_data_out     <= '0;
            fifo_empty        <= 1'b1;
            fifo_almost_empty <= 1'b1;
        end else begin
            cnt_b = fq.size();
            fifo_empty        <= (cnt_b == 0);
            fifo_almost_empty <= (cnt_b <= 1);
            fifo_data_out     <= rd_d1;
            if (rd_seen) begin
                check("pop_nonempty", 32'(fq.size() != 0), 1);
                if (fq.size() != 0) rd_d1 <= fq.pop_front();
            end
            if (fq.size() < 4 && src_q.size() != 0) begin
                fq.push_back(src_q[0]);
                exp_q.push_back(src_q[0]);
                void'(src_q.pop_front());
            end
        end
    end

    // Output monitor and scoreboard compare.
    always @(negedge clk) begin
        logic [5:0] w;
        if (reset_L) begin
            rd_seen = fifo_rd;
            if (fifo_rd) begin
                rd_log.push_back(cyc);
                check("pop_flag_empty", 32'(fifo_empty), 0);
            end
            check("skid_bound", 32'(skid_count <= 2'(SKID_DEPTH)), 1);
            if (dest_push != '0) begin
                push_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("push_unexpected", 32'(dest_push), 0);
                end else begin
                    w = exp_q.pop_front();
                    check("push_data", 32'(dest_data_out), 32'(w));
                    check("push_dest", 32'(dest_push), 32'(onehot_of(w)));
                    check("push_af_clear", 32'(af_last[w[5:4]]), 0);
                end
            end
            af_last = dest_almost_full;
        end else begin
            rd_seen = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs;
        rd_log.delete();
        push_log.delete();
    endtask

    task automatic wait_rds(input int n, input string tag);
        int k;
        k = 0;
        while (rd_log.size() < n && k < 30) begin
            step(1);
            k++;
        end
        check(tag, 32'(k < 30), 1);
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int k;
        k = 0;
        while (!(exp_q.size() == 0 && src_q.size() == 0 && idle) && k < limit) begin
            step(1);
            k++;
        end
        check(tag, 32'(k < limit), 1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_fifo_rd"}, 32'(fifo_rd), 0);
        check({pfx, "_push"},    32'(dest_push), 0);
        check({pfx, "_data"},    32'(dest_data_out), 0);
        check({pfx, "_skid"},    32'(skid_count), 0);
        check({pfx, "_idle"},    32'(idle), 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(3);
        check_reset_outputs("rst");
        reset_L = 1'b1;
        step(2);

        // Streaming: four words, one per destination, back to back
        src_q.push_back(6'h05);
        src_q.push_back(6'h12);
        src_q.push_back(6'h2A);
        src_q.push_back(6'h3F);
        step(6);
        clear_logs();
        enable = 1'b1;
        step(10);
        enable = 1'b0;
        check("stream_rd_cnt", 32'(rd_log.size()), 4);
        check("stream_push_cnt", 32'(push_log.size()), 4);
        if (rd_log.size() == 4 && push_log.size() == 4) begin
            check("stream_rd_consec", 32'(rd_log[3] - rd_log[0]), 3);
            check("stream_push_consec", 32'(push_log[3] - push_log[0]), 3);
            // rd sampled in cycle c is popped by the edge opening c+1
            check("stream_first_lat", 32'(push_log[0] - (rd_log[0] + 1)), 3);
        end
        check("stream_idle", 32'(idle), 1);

        // Reset with two pops in flight
        src_q.push_back(6'h0A);
        src_q.push_back(6'h1B);
        src_q.push_back(6'h2C);
        src_q.push_back(6'h3D);
        step(6);
        clear_logs();
        enable = 1'b1;
        wait_rds(2, "midrst_rd_wait");
        reset_L = 1'b0;
        #1;
        check_reset_outputs("midrst");
        step(2);
        reset_L = 1'b1;
        clear_logs();
        step(8);
        check("midrst_no_push", 32'(push_log.size()), 0);
        check("midrst_no_rd", 32'(rd_log.size()), 0);
        enable = 1'b0;

        // Last-word guard
        src_q.push_back(6'h17);
        step(4);
        clear_logs();
        enable = 1'b1;
        step(8);
        enable = 1'b0;
        check("last_rd_cnt", 32'(rd_log.size()), 1);
        check("last_push_cnt", 32'(push_log.size()), 1);
        check("last_idle", 32'(idle), 1);

        // Head-of-line blocking on destination 2
        dest_almost_full = 4'b0100;
        src_q.push_back(6'h21);
        src_q.push_back(6'h01);
        src_q.push_back(6'h3F);
        src_q.push_back(6'h15);
        step(6);
        clear_logs();
        enable = 1'b1;
        step(10);
        check("hol_skid_full", 32'(skid_count), 3);
        check("hol_rd_stop", 32'(rd_log.size()), 3);
        check("hol_no_push", 32'(push_log.size()), 0);
        check("hol_busy", 32'(idle), 0);
        dest_almost_full = 4'b0000;
        wait_drain("hol_drain", 60);
        check("hol_push_cnt", 32'(push_log.size()), 4);
        check("hol_rd_cnt", 32'(rd_log.size()), 4);
        enable = 1'b0;

        // enable drop after two pops; two words stay in the FIFO
        src_q.push_back(6'h33);
        src_q.push_back(6'h04);
        src_q.push_back(6'h28);
        src_q.push_back(6'h19);
        step(6);
        clear_logs();
        enable = 1'b1;
        wait_rds(2, "endrop_rd_wait");
        enable = 1'b0;
        step(10);
        check("endrop_rd_cnt", 32'(rd_log.size()), 2);
        check("endrop_push_cnt", 32'(push_log.size()), 2);
        check("endrop_idle", 32'(idle), 1);

        // Random soak: 1000 new words plus the two left above
        for (int i = 0; i < 1000; i++) src_q.push_back(6'($urandom));
        clear_logs();
        begin
            int k;
            k = 0;
            while (!(exp_q.size() == 0 && src_q.size() == 0 && idle) && k < 40000) begin
                enable           = ($urandom_range(0, 9) != 0);
                dest_almost_full = 4'($urandom) & 4'($urandom);
                step(1);
                k++;
            end
            check("soak_done", 32'(k < 40000), 1);
        end
        enable           = 1'b0;
        dest_almost_full = '0;
        step(4);
        check("soak_push_cnt", 32'(push_log.size()), 1002);
        check("soak_idle", 32'(idle), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_dest_router.md
Name: fifo_dest_router

Overview:
Downstream consumer of the 4-entry FIFO. It pops words from the FIFO, absorbs the FIFO's registered read latency in a small skid buffer, and routes each word by its destination field (the word's MSBs) to one of NUM_DEST downstream FIFOs. It honours each destination's almost_full as backpressure and preserves word order (head-of-line blocking).

Parameters:
WORD_SIZE, 6, word width; word passes through unmodified.
DEST_BITS, 2, destination field = word[WORD_SIZE-1 -: DEST_BITS].
NUM_DEST, 4, number of destination ports (= 2**DEST_BITS).
RD_LAT, 2, cycles from a fifo_rd edge to valid fifo_data_out.

Ports:
clk  input  1  rising-edge clock
reset_L  input  1  asynchronous active-low reset
enable  input  1  1 = allow new pops; 0 = stop popping, drain in-flight words
fifo_empty  input  1  upstream FIFO empty flag
fifo_almost_empty  input  1  upstream FIFO almost_empty (threshold 1)
fifo_data_out  input  WORD_SIZE  upstream FIFO read data
fifo_rd  output  1  pop request to upstream FIFO
dest_almost_full  input  NUM_DEST  per-destination backpressure
dest_data_out  output  WORD_SIZE  routed word, shared by all destinations
dest_push  output  NUM_DEST  one-hot push strobe
idle  output  1  no in-flight pops, skid empty, no push this cycle
skid_count  output  2  current skid occupancy (0..RD_LAT+1)

Behaviour:
- Reset (async, reset_L=0):
  - fifo_rd=0, dest_push=0, dest_data_out=0, skid_count=0, idle=1.
  - In-flight pipe is cleared. Words in flight at reset are discarded.
- Pop tracking:
  - Valid pipe, RD_LAT bits deep.
  - fifo_rd high at edge t means fifo_data_out is captured into the skid at edge t+RD_LAT.
- Skid buffer:
  - Circular buffer, SKID_DEPTH = RD_LAT+1 (localparam).
  - Wrapping 2-bit read and write pointers.
  - Simultaneous write and dequeue in one cycle is legal; occupancy is unchanged.
- Pop rule: fifo_rd=1 in a cycle iff all of the following hold:
  - enable=1
  - fifo_empty=0
  - skid_count + inflight - deq_now < SKID_DEPTH, where deq_now is the dequeue happening this cycle
  - either fifo_almost_empty=0, or no pop was issued in the previous cycle
- Why the almost_empty gate: the FIFO flags update one cycle after a pop, so with a single word left the block must not pop back-to-back. The block never pops an empty FIFO.
- Sustained throughput: 1 word/cycle when the FIFO holds at least 2 words and the destination is not full.
- Route FSM (per cycle):
  - If the skid head is valid, take d = head[WORD_SIZE-1 -: DEST_BITS].
  - If dest_almost_full[d]=0 in that cycle: at the next edge dest_data_out<=head, dest_push<=one-hot(d), and the head is dequeued.
  - Otherwise dest_push<=0 and the head stays.
  - dest_push is high for exactly one cycle per word.
  - Output latency: minimum RD_LAT+1 edges from fifo_rd to dest_push.
- Ordering: strict FIFO order. A blocked head stalls all later words, including words for other destinations.
- Stall effect: a blocked head stops new pops once skid plus in-flight reaches SKID_DEPTH. The skid never overflows (assertion: write into a full skid is an error and must not occur).
- enable deassert: no new fifo_rd from the next cycle. In-flight words are still captured and routed. idle rises once drained.
- Boundary widths: skid_count saturates at SKID_DEPTH by construction. Pointers wrap modulo SKID_DEPTH, not a power of 2, so explicit wrap compare is required.

Decomposition:
- Shared package: WORD_SIZE, DEST_BITS, NUM_DEST, RD_LAT defaults; SKID_DEPTH derivation; dest-field extract function.
- One sub-module: router_skid (parameterised circular skid buffer with count, push, pop, head output).
- FSM, pop gating and output register live in fifo_dest_router.

Test Plan:
1. Reset mid-stream: reset_L=0 with 2 pops in flight -> all outputs 0, idle=1. After release, with FIFO empty, no push occurs.
2. Streaming: FIFO holds 0x05, 0x12, 0x2A, 0x3F, all dest AF=0 -> 4 consecutive fifo_rd cycles. Pushes dest_push=0001, 0010, 0100, 1000 with those data on 4 consecutive cycles; first push 3 edges after first fifo_rd.
3. Last-word guard: FIFO holds 1 word (almost_empty=1) -> single fifo_rd pulse, no rd in the following cycle, exactly one push.
4. Backpressure HOL: words 0x21 (dest 2) then 0x01 (dest 0), dest_almost_full=0100 for 10 cycles -> no push and fifo_rd stops with skid_count=3. When AF clears, 0x21 is pushed on dest 2, then 0x01 on dest 0, with no loss or duplication.
5. enable drop: enable=0 one cycle after 2 pops -> no further fifo_rd, 2 words pushed, then idle=1.
6. Random soak: 1000 words, random AF and enable -> scoreboard shows order preserved, the FIFO is never popped while fifo_empty=1, and no skid overflow.
